fetch_buffer: RTL

- Instruction fetch stage sitting directly upstream of decode.
- Owns the PC and drives a handshaked instruction memory with at most one outstanding request.
- Holds returned 16-bit instruction words and their PC+2 in a small FIFO, presenting them to decode with a valid/ready handshake.
- Handles redirects (branch/jump/JR from later stages), squashes in-flight fetches and stops fetching after a HALT word.

---
 rtl/fetch_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// Fetch stage: owns the PC, keeps at most one imem request in flight, buffers words for decode.
// A word reaches decode one cycle after its ack; a new request launches only if its word will fit.
module fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  output logic        halted,
  output logic        err
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [15:0] NOP     = 16'h0800;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_HALT} state_t;

  state_t        state, state_nx;
  logic [15:0]   pc;
  logic [15:0]   instr_mem [DEPTH];
  logic [15:0]   pcp2_mem  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_nx;
  logic          ack, redir, enq, deq, launch, credit;
  logic [15:0]   head_instr;

  function automatic logic is_halt(input logic [15:0] w);
    return w[15:11] == 5'b00000;
  endfunction

  assign imem_req    = (state == S_WAIT) || (state == S_DRAIN);
  assign ack         = imem_ack & imem_req;
  assign redir       = redirect & ~halted;
  assign instr_valid = (cnt != '0) & ~halted;
  assign deq         = instr_valid & instr_ready;
  assign enq         = ack & (state == S_WAIT) & ~redir;
  assign head_instr  = instr_mem[rd_ptr];
  assign instruction = instr_valid ? head_instr : NOP;
  assign pc_plus2    = (cnt != '0) ? pcp2_mem[rd_ptr] : pc + 16'd2;

  // Credit is judged on the occupancy the buffer will have after this edge.
  always_comb begin
    cnt_nx = cnt;
    if (enq && !deq)
      cnt_nx = cnt + 1'b1;
    else if (!enq && deq)
      cnt_nx = cnt - 1'b1;
  end

  assign credit = cnt_nx < DEPTH_C;

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    if (redir) begin
      state_nx = (imem_req && !imem_ack) ? S_DRAIN : S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (credit && !halted) begin
            launch   = 1'b1;
            state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack) begin
            if (is_halt(imem_data))
              state_nx = S_HALT;
            else if (credit)
              launch = 1'b1;
            else
              state_nx = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (ack)
            state_nx = S_FETCH;
        end
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (deq && is_halt(head_instr))
        halted <= 1'b1;
      if (redir) begin
        pc     <= {redirect_pc[15:1], 1'b0};
        err    <= err | redirect_pc[0];
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (launch) begin
          imem_addr <= pc;
          pc        <= pc + 16'd2;
        end
        if (enq)
          wr_ptr <= wr_ptr + 1'b1;
        if (deq)
          rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= imem_data;
      pcp2_mem[wr_ptr]  <= imem_addr + 16'd2;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(enq && !deq && cnt == DEPTH_C));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(deq && cnt == '0));

endmodule
